// File: rtl/mult_watchdog_if.sv
// Bundle of the monitored start/done/clear pulses and watchdog status for mult_watchdog.
// With MULT_WDOG_STATS_EN defined it also carries the flattened latency statistics.
interface mult_watchdog_if #(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 24
);
    logic                     limit_sel;
    logic [CNT_W-1:0]         limit_in;
    logic [NUM_CH-1:0]        start;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH-1:0]        clear;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        timeout;
    logic [NUM_CH-1:0]        overlap_err;
    logic [NUM_CH-1:0]        spurious_done;
    logic                     timeout_any;
`ifdef MULT_WDOG_STATS_EN
    logic [NUM_CH*CNT_W-1:0]  last_lat;
    logic [NUM_CH*CNT_W-1:0]  max_lat;
    logic [NUM_CH*16-1:0]     done_cnt;
`endif

    modport master (
        output limit_sel, limit_in, start, done, clear,
`ifdef MULT_WDOG_STATS_EN
        input  last_lat, max_lat, done_cnt,
`endif
        input  busy, timeout, overlap_err, spurious_done, timeout_any
    );

    modport slave (
        input  limit_sel, limit_in, start, done, clear,
`ifdef MULT_WDOG_STATS_EN
        output last_lat, max_lat, done_cnt,
`endif
        output busy, timeout, overlap_err, spurious_done, timeout_any
    );
endinterface

// File: rtl/mult_watchdog.sv
// Per-channel transaction watchdog: IDLE/RUN/EXPIRED FSM with a saturating cycle counter per channel.
// Optional latency statistics are built when MULT_WDOG_STATS_EN is defined.
module mult_watchdog #(
    parameter int NUM_CH    = 1,
    parameter int CNT_W     = 24,
    parameter int DEF_LIMIT = 6553600
) (
    input  logic          clk,
    input  logic          rst,
    mult_watchdog_if.slave wd
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXP} state_t;

    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LIMIT);

    logic [CNT_W-1:0] lim;
    assign lim = wd.limit_sel ? wd.limit_in : DEF_L;

    wire [NUM_CH-1:0] busy_w;
    wire [NUM_CH-1:0] to_w;
    wire [NUM_CH-1:0] ovl_w;
    wire [NUM_CH-1:0] spur_w;
`ifdef MULT_WDOG_STATS_EN
    wire [NUM_CH*CNT_W-1:0] last_w;
    wire [NUM_CH*CNT_W-1:0] max_w;
    wire [NUM_CH*16-1:0]    dcnt_w;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             ovl_q, ovl_d;
            logic             spur_q, spur_d;
            logic             busy_q, to_q;
            logic             acc_done;
            logic [CNT_W:0]   cnt_p1;
            logic [CNT_W-1:0] cnt_inc;
            logic             expire;

            // cnt_p1 is one bit wider so the limit compare never sees a wrapped value
            assign cnt_p1  = {1'b0, cnt_q} + (CNT_W+1)'(1);
            assign cnt_inc = (&cnt_q) ? cnt_q : cnt_p1[CNT_W-1:0];
            assign expire  = (lim != '0) && (cnt_p1 >= {1'b0, lim});

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                ovl_d    = ovl_q;
                spur_d   = spur_q;
                acc_done = 1'b0;
                if (wd.clear[gi]) begin
                    ovl_d  = 1'b0;
                    spur_d = 1'b0;
                end
                unique case (state_q)
                    ST_IDLE: begin
                        if (wd.start[gi]) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else if (wd.done[gi]) begin
                            spur_d = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (wd.done[gi]) begin
                            acc_done = 1'b1;
                            cnt_d    = '0;
                            if (!wd.start[gi]) state_d = ST_IDLE;
                        end else if (wd.start[gi]) begin
                            ovl_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_inc;
                            if (expire) state_d = ST_EXP;
                        end
                    end
                    ST_EXP: begin
                        if (wd.clear[gi]) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ovl_q   <= 1'b0;
                    spur_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    to_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    ovl_q   <= ovl_d;
                    spur_q  <= spur_d;
                    busy_q  <= (state_d == ST_RUN);
                    to_q    <= (state_d == ST_EXP);
                end
            end

            assign busy_w[gi] = busy_q;
            assign to_w[gi]   = to_q;
            assign ovl_w[gi]  = ovl_q;
            assign spur_w[gi] = spur_q;

`ifdef MULT_WDOG_STATS_EN
            logic [CNT_W-1:0] last_q, max_q;
            logic [15:0]      dcnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    last_q <= '0;
                    max_q  <= '0;
                    dcnt_q <= '0;
                end else if (acc_done) begin
                    last_q <= cnt_inc;
                    if (cnt_inc > max_q) max_q <= cnt_inc;
                    if (dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 16'd1;
                end
            end

            assign last_w[gi*CNT_W +: CNT_W] = last_q;
            assign max_w[gi*CNT_W +: CNT_W]  = max_q;
            assign dcnt_w[gi*16 +: 16]       = dcnt_q;
`endif
        end
    endgenerate

    assign wd.busy          = busy_w;
    assign wd.timeout       = to_w;
    assign wd.overlap_err   = ovl_w;
    assign wd.spurious_done = spur_w;
    assign wd.timeout_any   = |to_w;
`ifdef MULT_WDOG_STATS_EN
    assign wd.last_lat = last_w;
    assign wd.max_lat  = max_w;
    assign wd.done_cnt = dcnt_w;
`endif
endmodule

// File: tb/tb_mult_watchdog.sv
// Directed bench for mult_watchdog: 4-channel instance plus an 8-bit instance for the default limit.
// Statistics checks are compiled in when MULT_WDOG_STATS_EN is defined.
module tb_mult_watchdog;
    localparam int NCH = 4;
    localparam int CW  = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_watchdog_if #(.NUM_CH(NCH), .CNT_W(CW)) wif ();
    mult_watchdog #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .wd  (wif)
    );

    mult_watchdog_if #(.NUM_CH(1), .CNT_W(8)) wif8 ();
    mult_watchdog #(.NUM_CH(1), .CNT_W(8), .DEF_LIMIT(200)) dut8 (
        .clk (clk),
        .rst (rst),
        .wd  (wif8)
    );

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input string tag, input logic [3:0] b, input logic [3:0] t,
                            input logic [3:0] o, input logic [3:0] s);
        exp_t e;
        e.tag = tag;
        e.v   = {b, t, o, s, |t};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [16:0] obs;
        e   = sb.pop_front();
        obs = {wif.busy, wif.timeout, wif.overlap_err, wif.spurious_done, wif.timeout_any};
        n_tests++;
        $display("[TB] %s busy=%b to=%b ovl=%b spur=%b any=%b", e.tag,
                 obs[16:13], obs[12:9], obs[8:5], obs[4:1], obs[0]);
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
        end
    endtask

    // Drive one edge worth of pulses, record what the outputs must show after it, then compare.
    task automatic step(input string tag, input logic [3:0] st, input logic [3:0] dn,
                        input logic [3:0] cl, input logic [3:0] b, input logic [3:0] t,
                        input logic [3:0] o, input logic [3:0] s);
        wif.start = st;
        wif.done  = dn;
        wif.clear = cl;
        push_exp(tag, b, t, o, s);
        @(posedge clk);
        #1;
        wif.start = '0;
        wif.done  = '0;
        wif.clear = '0;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic b, input logic t);
        n_tests++;
        $display("[TB] %s busy=%b to=%b", tag, wif8.busy, wif8.timeout);
        assert ({wif8.busy, wif8.timeout, wif8.timeout_any} === {b, t, t}) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag,
                   {wif8.busy, wif8.timeout, wif8.timeout_any}, {b, t, t});
        end
    endtask

`ifdef MULT_WDOG_STATS_EN
    task automatic check_stats(input string tag, input int ch, input logic [CW-1:0] last,
                               input logic [CW-1:0] mx, input logic [15:0] cnt);
        logic [2*CW+15:0] obs;
        obs = {wif.last_lat[ch*CW +: CW], wif.max_lat[ch*CW +: CW], wif.done_cnt[ch*16 +: 16]};
        n_tests++;
        $display("[TB] %s last=%0d max=%0d cnt=%0d", tag,
                 obs[2*CW+15:CW+16], obs[CW+15:16], obs[15:0]);
        assert (obs === {last, mx, cnt}) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, {last, mx, cnt});
        end
    endtask
`endif

    initial begin
        wif.limit_sel  = 1'b1;
        wif.limit_in   = 24'd5;
        wif.start      = '0;
        wif.done       = '0;
        wif.clear      = '0;
        wif8.limit_sel = 1'b0;
        wif8.limit_in  = '0;
        wif8.start     = '0;
        wif8.done      = '0;
        wif8.clear     = '0;

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check_out();
        check8("d8_reset", 1'b0, 1'b0);

        // basic expiry, limit 5; pulses while EXPIRED are ignored
        step("t1_start", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 4; k++)
            step("t1_run", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t1_expire", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 6; k <= 20; k++)
            step("t1_hold", (k == 10) ? 4'b0001 : 4'b0000, (k == 12) ? 4'b0001 : 4'b0000,
                 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step("t1_clear", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // done at the expiry edge wins
        step("t2_start", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 4; k++)
            step("t2_run", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t2_done5", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
`ifdef MULT_WDOG_STATS_EN
        check_stats("t2_stats1", 0, 24'd5, 24'd5, 16'd1);
`endif
        step("t2_start2", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t2_run2", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t2_run2", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t2_done3", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
`ifdef MULT_WDOG_STATS_EN
        check_stats("t2_stats2", 0, 24'd3, 24'd5, 16'd2);
`endif

        // protocol errors
        step("t3_spur", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step("t3_spur_clr", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t3_idle_st_dn", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_done", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        wif.limit_in = 24'd4;
        step("t3_ovl_s0", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_ovl_e1", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_ovl_s2", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step("t3_ovl_clr", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_ovl_e4", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_ovl_e5", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_ovl_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step("t3_ovl_out", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // start+done in RUN re-arms without error
        step("t3_rearm_s0", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_rearm_e1", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_rearm_e2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 3; k <= 5; k++)
            step("t3_rearm_run", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t3_rearm_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step("t3_rearm_out", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // multi-channel independence
        wif.limit_in = 24'd10;
        step("t4_start", 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 2; k++)
            step("t4_run", 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step("t4_done1", 4'b0000, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 4; k <= 8; k++)
            step("t4_run", 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
        step("t4_done3", 4'b0000, 4'b1000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
        step("t4_expire", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
        step("t4_clear", 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // limit 0 never expires; lowering the limit mid-run expires at the next edge
        wif.limit_in = 24'd0;
        step("t5_start", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        idle(1000);
        step("t5_long", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        wif.limit_in = 24'd3;
        step("t5_lower", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step("t5_clear", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // reset with ch0 in RUN and ch1 in EXPIRED, start pulses present during reset
        wif.limit_in = 24'd2;
        step("t6_s1", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        step("t6_e1", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        step("t6_e2", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wif.limit_in = 24'd100;
        step("t6_s0", 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0100);
        rst = 1'b1;
        step("t6_rst", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
`ifdef MULT_WDOG_STATS_EN
        check_stats("t6_stats_rst", 0, 24'd0, 24'd0, 16'd0);
`endif
        wif.limit_in = 24'd3;
        step("t6_cold_s0", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t6_cold_e1", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t6_cold_e2", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("t6_cold_e3", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

        // default limit on the 8-bit instance: expiry 200 edges after start
        wif8.start = 1'b1;
        @(posedge clk);
        #1;
        wif8.start = 1'b0;
        check8("d8_start", 1'b1, 1'b0);
        idle(199);
        check8("d8_edge199", 1'b1, 1'b0);
        idle(1);
        check8("d8_edge200", 1'b0, 1'b1);

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_watchdog.md
Name: mult_watchdog

Overview:
- Parametrised, synthesizable successor to the multiplier bench's single global time-out.
- Tracks up to NUM_CH independent start/done transactions, each with its own cycle counter, and flags any channel whose transaction exceeds a runtime-programmable limit.
- Sits beside the DUT in the multiplier testbench, or in an SoC wrapper.
- Feeds the grader/scoreboard with per-channel time-out, busy and protocol-error status instead of a single hard $finish.

Parameters:
- NUM_CH, 1, number of independent channels monitored.
- CNT_W, 24, width of each channel's cycle counter and of the limit input.
- DEF_LIMIT, 6553600, limit used when limit_sel=0; sized for a 256x256 operand sweep at 100 cycles each.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- limit_sel  in  1  0 = use DEF_LIMIT; 1 = use limit_in.
- limit_in  in  CNT_W  runtime limit in cycles; 0 = channel never expires.
- start  in  NUM_CH  per-channel one-cycle start pulse.
- done  in  NUM_CH  per-channel one-cycle completion pulse.
- clear  in  NUM_CH  per-channel clear of sticky status.
- busy  out  NUM_CH  channel is in RUN.
- timeout  out  NUM_CH  sticky; channel is in EXPIRED.
- overlap_err  out  NUM_CH  sticky; start seen while in RUN.
- spurious_done  out  NUM_CH  sticky; done seen while in IDLE.
- timeout_any  out  1  OR of timeout.

Behaviour:
- Reset: all channels go to IDLE; counters = 0; every output = 0. Reset during RUN or EXPIRED aborts without asserting any flag. Reset overrides all other inputs in that cycle.
- Effective limit L is selected per cycle by limit_sel. All outputs are registered (no combinational input-to-output path), except timeout_any, which is an OR of registered bits.
- Per-channel FSM states: IDLE, RUN, EXPIRED.
- IDLE:
  - start=1 → RUN, count<=0.
  - done=1 without start → stay in IDLE, set spurious_done.
  - start and done in the same cycle → start wins; done is ignored and no error is flagged.
- RUN:
  - Each edge: count<=count+1. count saturates at all-ones and never wraps.
  - done=1 → IDLE; the transaction latency is count+1 edges.
  - done=0, L!=0 and count+1>=L → EXPIRED. With start at edge k and no done, timeout goes high immediately after edge k+L.
  - done and expiry condition in the same cycle → done wins; go to IDLE.
  - start=1 without done → set overlap_err; count<=0 (re-arm); stay in RUN.
  - start and done together → count the completion, then re-arm: stay in RUN, count<=0, no error.
  - L lowered mid-run to a value <= count+1 → expires at that edge.
  - L=0 → never expires; count saturates.
- EXPIRED:
  - timeout=1 and stays set; start and done are ignored.
  - clear=1 → IDLE; clears timeout.
- clear in IDLE or RUN clears overlap_err and spurious_done only; the FSM state is not affected.
- Channels are fully independent. Simultaneous events on different channels must not interact.

Optional Feature:
- Macro MULT_WDOG_STATS_EN.
- Defined: adds outputs last_lat (NUM_CH*CNT_W), max_lat (NUM_CH*CNT_W) and done_cnt (NUM_CH*16), all flattened with channel 0 in the LSBs.
  - On each accepted done: last_lat<=count+1; max_lat<=max(max_lat, count+1).
  - done_cnt increments on each accepted done and saturates at 0xFFFF.
  - rst zeroes all three; clear does not affect them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset and basic expiry: NUM_CH=1, limit_sel=1, limit_in=5, start at edge 0, no done → busy=1 after edges 0..4; timeout=1 and timeout_any=1 after edge 5; timeout holds through edge 20; clear at edge 21 → timeout=0, busy=0.
- Completion beats expiry: limit_in=5, start at edge 0, done at edge 5 → no timeout; IDLE after edge 5. With STATS: last_lat=5, max_lat=5, done_cnt=1. A second run with done at edge 3 → last_lat=3, max_lat=5, done_cnt=2.
- Protocol errors: done while IDLE → spurious_done=1. start at edge 0 and again at edge 2, limit 4 → overlap_err=1 and timeout after edge 6, not edge 4.
- Multi-channel independence: NUM_CH=4, limit_in=10; start ch0..3 at edge 0; done ch1 at edge 3, done ch3 at edge 9 → timeout=4'b0101 after edge 10; busy=0 for all channels.
- Limit edge cases: limit_in=0, start, run 1000 cycles → no timeout. Then limit_in changed to 3 mid-run → timeout one edge later. With limit_sel=0 and CNT_W=8 (DEF_LIMIT overridden to 200) → expiry 200 edges after start.
- Reset mid-operation: rst asserted while ch0 is in RUN and ch1 is in EXPIRED → all outputs 0 after that edge; a new start behaves as from cold reset.
